spi_xfer_sequencer: RTL and testbench

Transaction sequencer and two-port arbiter for the SPI master core in the SoC. Requesters (SD-card loader on port 0, debug/config engine on port 1) hand it byte streams. It grants one requester per transaction and drives the SPI core's register port: slave-select, SSO, TX write, status poll and RX read. Each returned byte goes back to the owning requester. Chip select stays asserted across a whole multi-byte transaction.

---
 rtl/spi_xfer_sequencer_if.sv | 33 +++
 rtl/spi_xfer_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_sequencer_if.sv
// rtl/spi_xfer_sequencer_if.sv - requester byte streams and SPI core register port of the sequencer
interface spi_xfer_sequencer_if;
    logic [1:0]  req;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_last;
    logic [7:0]  tx_data0;
    logic [7:0]  tx_data1;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        spi_select;
    logic        read_n;
    logic        write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;

    // master: the sequencer, which owns the core register port and grants requesters
    modport master (
        input  req, tx_valid, tx_last, tx_data0, tx_data1, data_to_cpu,
        output tx_ready, rx_valid, rx_data, gnt, done, err,
               spi_select, read_n, write_n, mem_addr, data_from_cpu
    );

    modport slave (
        output req, tx_valid, tx_last, tx_data0, tx_data1, data_to_cpu,
        input  tx_ready, rx_valid, rx_data, gnt, done, err,
               spi_select, read_n, write_n, mem_addr, data_from_cpu
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - two-port round-robin transaction sequencer driving the SPI core registers
module spi_xfer_sequencer #(
    parameter int          POLL_LIMIT = 255,
    parameter logic [15:0] SS_MASK    = 16'h0001
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_xfer_sequencer_if.master bus
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ARB     = 4'd1;
    localparam logic [3:0] S_CLR     = 4'd2;
    localparam logic [3:0] S_SEL     = 4'd3;
    localparam logic [3:0] S_SSO_ON  = 4'd4;
    localparam logic [3:0] S_WAIT_TX = 4'd5;
    localparam logic [3:0] S_WR_TX   = 4'd6;
    localparam logic [3:0] S_POLL    = 4'd7;
    localparam logic [3:0] S_RD_RX   = 4'd8;
    localparam logic [3:0] S_DELIVER = 4'd9;
    localparam logic [3:0] S_SSO_OFF = 4'd10;
    localparam logic [3:0] S_FIN     = 4'd11;

    localparam logic [7:0] LIMIT8 = (POLL_LIMIT > 255) ? 8'd255 : 8'(POLL_LIMIT);

    localparam logic [2:0] A_RXDATA = 3'd0;
    localparam logic [2:0] A_TXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_SS     = 3'd5;

    logic [3:0] state;
    logic [1:0] phase;
    logic [1:0] gnt_q;
    logic       ptr;
    logic       abort_q;
    logic       last_q;
    logic [7:0] byte_q;
    logic [7:0] poll_cnt;
    logic       stat_rrdy;
    logic       stat_err;
    logic [7:0] rx_data_q;

    logic       g;
    logic       access_state;
    logic       acc_active;
    logic       acc_end;
    logic       unused_rd_bits;

    assign g            = gnt_q[1];
    assign access_state = state inside {S_CLR, S_SEL, S_SSO_ON, S_WR_TX, S_POLL, S_RD_RX, S_SSO_OFF};
    // Every register access: phases 0 and 1 drive the strobes, phase 2 is the idle gap
    assign acc_active   = access_state && (phase != 2'd2);
    assign acc_end      = access_state && (phase == 2'd2);

    assign unused_rd_bits = ^bus.data_to_cpu[15:9];

    always_comb begin
        bus.spi_select    = 1'b0;
        bus.read_n        = 1'b1;
        bus.write_n       = 1'b1;
        bus.mem_addr      = 3'd0;
        bus.data_from_cpu = 16'h0000;
        if (acc_active) begin
            bus.spi_select = 1'b1;
            case (state)
                S_CLR: begin
                    bus.mem_addr = A_STATUS;
                    bus.write_n  = 1'b0;
                end
                S_SEL: begin
                    bus.mem_addr      = A_SS;
                    bus.write_n       = 1'b0;
                    bus.data_from_cpu = SS_MASK;
                end
                S_SSO_ON: begin
                    bus.mem_addr      = A_CTRL;
                    bus.write_n       = 1'b0;
                    bus.data_from_cpu = 16'h0400;
                end
                S_WR_TX: begin
                    bus.mem_addr      = A_TXDATA;
                    bus.write_n       = 1'b0;
                    bus.data_from_cpu = {8'h00, byte_q};
                end
                S_POLL: begin
                    bus.mem_addr = A_STATUS;
                    bus.read_n   = 1'b0;
                end
                S_RD_RX: begin
                    bus.mem_addr = A_RXDATA;
                    bus.read_n   = 1'b0;
                end
                S_SSO_OFF: begin
                    bus.mem_addr = A_CTRL;
                    bus.write_n  = 1'b0;
                end
                default: begin
                    bus.spi_select = 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.tx_ready = (state == S_WAIT_TX) ? (bus.tx_valid & gnt_q) : 2'b00;
    assign bus.rx_valid = (state == S_DELIVER) ? gnt_q : 2'b00;
    assign bus.done     = (state == S_FIN) ? gnt_q : 2'b00;
    assign bus.err      = (state == S_FIN && abort_q) ? gnt_q : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            gnt_q     <= 2'b00;
            ptr       <= 1'b0;
            abort_q   <= 1'b0;
            last_q    <= 1'b0;
            byte_q    <= 8'h00;
            poll_cnt  <= 8'h00;
            stat_rrdy <= 1'b0;
            stat_err  <= 1'b0;
            rx_data_q <= 8'h00;
        end else begin
            if (access_state && phase != 2'd2) begin
                phase <= phase + 2'd1;
            end else begin
                phase <= 2'd0;
            end

            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    // The pointer names the port that was not served last
                    if (bus.req[ptr]) begin
                        gnt_q <= ptr ? 2'b10 : 2'b01;
                        state <= S_CLR;
                    end else if (bus.req[~ptr]) begin
                        gnt_q <= ptr ? 2'b01 : 2'b10;
                        state <= S_CLR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CLR: begin
                    if (acc_end) begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (acc_end) begin
                        state <= S_SSO_ON;
                    end
                end
                S_SSO_ON: begin
                    if (acc_end) begin
                        state <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    if (bus.tx_valid[g]) begin
                        byte_q <= g ? bus.tx_data1 : bus.tx_data0;
                        last_q <= bus.tx_last[g];
                        state  <= S_WR_TX;
                    end else if (!bus.req[g]) begin
                        state <= S_SSO_OFF;
                    end
                end
                S_WR_TX: begin
                    poll_cnt <= 8'h00;
                    if (acc_end) begin
                        state <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (phase == 2'd1) begin
                        stat_rrdy <= bus.data_to_cpu[7];
                        stat_err  <= bus.data_to_cpu[8];
                        if (poll_cnt != 8'hFF) begin
                            poll_cnt <= poll_cnt + 8'd1;
                        end
                    end
                    if (acc_end) begin
                        if (stat_rrdy) begin
                            state <= S_RD_RX;
                        end else if (stat_err || poll_cnt >= LIMIT8) begin
                            abort_q <= 1'b1;
                            state   <= S_SSO_OFF;
                        end
                    end
                end
                S_RD_RX: begin
                    if (phase == 2'd1) begin
                        rx_data_q <= bus.data_to_cpu[7:0];
                    end
                    if (acc_end) begin
                        state <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    state <= last_q ? S_SSO_OFF : S_WAIT_TX;
                end
                S_SSO_OFF: begin
                    if (acc_end) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    gnt_q   <= 2'b00;
                    abort_q <= 1'b0;
                    ptr     <= ~g;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench for spi_xfer_sequencer with a stub SPI core
module tb_spi_xfer_sequencer;
    localparam int          LIMIT = 4;
    localparam logic [15:0] SSM   = 16'h0001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_sequencer_if bus ();

    spi_xfer_sequencer #(.POLL_LIMIT(LIMIT), .SS_MASK(SSM)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        int          port;
        int          n;
        logic [63:0] bytes;
        logic [31:0] ks;
        int          mode;
        int          abort_at;
        int          exp_err;
        int          exp_nrx;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    // requester models
    logic [63:0] cur_bytes [2];
    int          cur_n [2];
    int          idx [2];
    bit          adv [2];
    bit          active [2];
    int          rearm [2];

    // stub core: per-byte poll counts, mode 1 = never ready, mode 2 = E bit
    logic [31:0] cur_ks;
    int          cur_mode;
    int          cur_abort;
    int          w1_cnt;
    int          poll_m;
    logic [7:0]  loop_byte;
    int          act_len;
    logic [19:0] cur_acc;

    logic [19:0] acc_log [$];
    logic [8:0]  rx_log [$];
    int          gnt_log [$];
    int          txn_cyc, done_cnt, done_port, done_err, done_cyc, gnt_rise_cyc;
    int          proto_err, gnt_bad, stray;
    logic [1:0]  gnt_prev;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] core_read(input logic [2:0] addr);
        int b;
        int k;
        b = (w1_cnt > 0) ? w1_cnt - 1 : 0;
        k = int'(cur_ks[4*b +: 4]);
        if (addr == 3'd0) return {8'h00, loop_byte};
        if (addr != 3'd2) return 16'h0000;
        if (cur_mode == 1 && b == cur_abort) return 16'h0000;
        if (poll_m < k) return 16'h0000;
        if (cur_mode == 2 && b == cur_abort) return 16'h0100;
        return 16'h0080;
    endfunction

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            bit v;
            int i;
            i = (idx[p] < 8) ? idx[p] : 0;
            v = active[p] && (idx[p] < cur_n[p]);
            bus.req[p]      = active[p];
            bus.tx_valid[p] = v;
            bus.tx_last[p]  = v && (idx[p] == cur_n[p] - 1);
            if (p == 0) bus.tx_data0 = v ? cur_bytes[0][8*i +: 8] : 8'h00;
            else        bus.tx_data1 = v ? cur_bytes[1][8*i +: 8] : 8'h00;
        end
    endtask

    task automatic clr_logs();
        acc_log.delete();
        rx_log.delete();
        gnt_log.delete();
        done_cnt = 0; done_port = -1; done_err = -1; done_cyc = -1; gnt_rise_cyc = -1;
        proto_err = 0; gnt_bad = 0; stray = 0; txn_cyc = 0;
    endtask

    task automatic clr_state();
        for (int p = 0; p < 2; p++) begin
            active[p] = 0; idx[p] = 0; adv[p] = 0; cur_n[p] = 0; rearm[p] = 0; cur_bytes[p] = '0;
        end
        cur_ks = '0; cur_mode = 0; cur_abort = 0;
        act_len = 0; cur_acc = '0; w1_cnt = 0; poll_m = 0; loop_byte = 8'h00; gnt_prev = 2'b00;
        bus.data_to_cpu = 16'h0000;
        clr_logs();
        drive();
    endtask

    task automatic tick();
        logic [19:0] a;
        @(negedge clk);
        txn_cyc++;
        if (bus.spi_select) begin
            a = {~bus.write_n, bus.mem_addr, bus.write_n ? 16'h0000 : bus.data_from_cpu};
            if (act_len == 0) begin
                acc_log.push_back(a);
                cur_acc = a;
                if (!bus.write_n && bus.mem_addr == 3'd2) w1_cnt = 0;
                if (!bus.write_n && bus.mem_addr == 3'd1) begin
                    w1_cnt++; poll_m = 0; loop_byte = bus.data_from_cpu[7:0];
                end
                if (!bus.read_n && bus.mem_addr == 3'd2) poll_m++;
            end else if (a != cur_acc) begin
                proto_err++;
            end
            if (bus.read_n == bus.write_n) proto_err++;
            act_len++;
            if (act_len > 2) proto_err++;
            // valid read data only in the second strobe cycle
            if (act_len == 2) bus.data_to_cpu = core_read(bus.mem_addr);
            else bus.data_to_cpu = (bus.mem_addr == 3'd0) ? {8'h00, ~loop_byte} : 16'h0000;
        end else begin
            if (act_len != 0 && act_len != 2) proto_err++;
            act_len = 0;
            if (!bus.read_n || !bus.write_n) proto_err++;
            bus.data_to_cpu = 16'h0000;
        end

        if (bus.gnt == 2'b11) gnt_bad++;
        if (bus.gnt != 2'b00 && gnt_prev == 2'b00) begin
            gnt_log.push_back(int'(bus.gnt[1]));
            gnt_rise_cyc = txn_cyc;
        end
        gnt_prev = bus.gnt;

        for (int p = 0; p < 2; p++) begin
            if (bus.rx_valid[p]) rx_log.push_back({1'(p), bus.rx_data});
            if (bus.err[p] && !bus.done[p]) stray++;
            if (bus.tx_ready[p] && !(bus.tx_valid[p] && bus.gnt[p])) stray++;
            if (adv[p]) begin idx[p]++; adv[p] = 0; end
            if (bus.tx_ready[p]) adv[p] = 1;
            if (bus.done[p]) begin
                done_cnt++; done_port = p; done_err = int'(bus.err[p]); done_cyc = txn_cyc;
                if (rearm[p] > 0) begin rearm[p]--; idx[p] = 0; adv[p] = 0; end
                else active[p] = 0;
            end
            if (active[p] && cur_n[p] == 0 && bus.gnt[p]) active[p] = 0;
        end
        drive();
    endtask

    task automatic run_one(input string tag, input int port, input int n, input logic [63:0] bytes,
                           input logic [31:0] ks, input int mode, input int abort_at,
                           input int exp_err, input int exp_nrx);
        logic [19:0] exp_q [$];
        int exp_cyc;
        int budget;
        int m;
        clr_logs();
        cur_ks = ks; cur_mode = mode; cur_abort = abort_at;
        cur_bytes[port] = bytes; cur_n[port] = n; idx[port] = 0; adv[port] = 0;
        rearm[port] = 0; active[port] = 1;
        drive();

        // expected register accesses and done cycle, from the transaction rules
        exp_q.push_back({1'b1, 3'd2, 16'h0000});
        exp_q.push_back({1'b1, 3'd5, SSM});
        exp_q.push_back({1'b1, 3'd3, 16'h0400});
        exp_cyc = 11;
        if (n == 0) exp_cyc += 1;
        for (int b = 0; b < n; b++) begin
            int k;
            bit ab;
            int reads;
            k = int'(ks[4*b +: 4]);
            ab = (mode != 0 && b == abort_at);
            reads = (ab && mode == 1) ? LIMIT : k;
            exp_q.push_back({1'b1, 3'd1, 8'h00, bytes[8*b +: 8]});
            repeat (reads) exp_q.push_back({1'b0, 3'd2, 16'h0000});
            exp_cyc += 4 + 3 * reads;
            if (ab) break;
            exp_q.push_back({1'b0, 3'd0, 16'h0000});
            exp_cyc += 4;
        end
        exp_q.push_back({1'b1, 3'd3, 16'h0000});
        exp_cyc += 3;

        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        repeat (2) tick();

        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_port"}, done_port, port);
        chk({tag, "_err"}, done_err, exp_err);
        chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
        chk({tag, "_gnt_latency"}, gnt_rise_cyc, 2);
        chk({tag, "_rx_count"}, rx_log.size(), exp_nrx);
        m = (rx_log.size() < exp_nrx) ? rx_log.size() : exp_nrx;
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_rx%0d", tag, i), int'(rx_log[i]), int'({1'(port), bytes[8*i +: 8]}));
        chk({tag, "_acc_count"}, acc_log.size(), exp_q.size());
        m = (acc_log.size() < exp_q.size()) ? acc_log.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_acc%0d", tag, i), int'(acc_log[i]), int'(exp_q[i]));
        chk({tag, "_bus_protocol"}, proto_err, 0);
        chk({tag, "_gnt_onehot"}, gnt_bad, 0);
        chk({tag, "_stray_pulses"}, stray, 0);
    endtask

    vec_t vecs [7];

    initial begin
        int budget;
        int sso;
        clr_state();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt_pulses", int'({bus.gnt, bus.tx_ready, bus.rx_valid, bus.done, bus.err}), 0);
        chk("rst_strobes", int'({bus.spi_select, bus.read_n, bus.write_n}), 3);
        chk("rst_addr_data", int'({bus.mem_addr, bus.data_from_cpu}), 0);
        chk("rst_rx_data", int'(bus.rx_data), 0);
        reset_n = 1'b1;

        vecs[0] = '{0, 1, 64'hA5, 32'h1, 0, 0, 0, 1};
        vecs[1] = '{1, 6, 64'h0000_9500_0000_0040, 32'h0012_3412, 0, 0, 0, 6};
        vecs[2] = '{0, 1, 64'h3C, 32'h1, 1, 0, 1, 0};
        vecs[3] = '{1, 2, 64'h2211, 32'h23, 2, 1, 1, 1};
        vecs[4] = '{0, 0, 64'h0, 32'h0, 0, 0, 0, 0};
        vecs[5] = '{1, 1, 64'hFF, 32'h4, 0, 0, 0, 1};
        vecs[6] = '{0, 3, 64'h03_0201, 32'h444, 1, 2, 1, 2};
        for (int v = 0; v < 7; v++) begin
            run_one($sformatf("vec%0d", v), vecs[v].port, vecs[v].n, vecs[v].bytes, vecs[v].ks,
                    vecs[v].mode, vecs[v].abort_at, vecs[v].exp_err, vecs[v].exp_nrx);
            if (v == 1) begin
                sso = 0;
                foreach (acc_log[i]) if (acc_log[i][18:16] == 3'd3) sso++;
                chk("multi_sso_pair", sso, 2);
            end
        end

        for (int r = 0; r < 8; r++) begin
            int port, n, mode, ab;
            logic [63:0] bytes;
            logic [31:0] ks;
            port = $urandom_range(0, 1);
            n = $urandom_range(1, 6);
            bytes = {$urandom, $urandom};
            ks = '0;
            for (int b = 0; b < 8; b++) ks[4*b +: 4] = 4'($urandom_range(1, LIMIT));
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = 0;
            ab = $urandom_range(0, n - 1);
            run_one($sformatf("rnd%0d", r), port, n, bytes, ks, mode, ab,
                    (mode != 0) ? 1 : 0, (mode != 0) ? ab : n);
        end

        // contention: both request from reset, port 0 re-requests once
        reset_n = 1'b0;
        @(negedge clk);
        clr_state();
        cur_ks = 32'h1111_1111;
        cur_bytes[0] = 64'h5A; cur_n[0] = 1; active[0] = 1; rearm[0] = 1;
        cur_bytes[1] = 64'hC3; cur_n[1] = 1; active[1] = 1;
        drive();
        reset_n = 1'b1;
        budget = 0;
        while (done_cnt < 3 && budget < 3000) begin
            tick();
            budget++;
        end
        repeat (2) tick();
        chk("cont_done_count", done_cnt, 3);
        chk("cont_gnt_count", gnt_log.size(), 3);
        if (gnt_log.size() >= 3) begin
            chk("cont_gnt0", gnt_log[0], 0);
            chk("cont_gnt1", gnt_log[1], 1);
            chk("cont_gnt2", gnt_log[2], 0);
        end
        chk("cont_onehot", gnt_bad, 0);
        chk("cont_rx_count", rx_log.size(), 3);
        if (rx_log.size() >= 3) begin
            chk("cont_rx0", int'(rx_log[0]), int'({1'b0, 8'h5A}));
            chk("cont_rx1", int'(rx_log[1]), int'({1'b1, 8'hC3}));
            chk("cont_rx2", int'(rx_log[2]), int'({1'b0, 8'h5A}));
        end
        chk("cont_bus_protocol", proto_err, 0);

        // reset asserted while polling a never-ready core
        clr_state();
        cur_mode = 1; cur_ks = 32'h1;
        cur_bytes[1] = 64'h77; cur_n[1] = 1; active[1] = 1;
        drive();
        budget = 0;
        while (acc_log.size() < 5 && budget < 500) begin
            tick();
            budget++;
        end
        chk("rstpoll_reached_poll", int'(acc_log.size() >= 5 && acc_log[4] == {1'b0, 3'd2, 16'h0000}), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstpoll_gnt_pulses", int'({bus.gnt, bus.tx_ready, bus.rx_valid, bus.done, bus.err}), 0);
        chk("rstpoll_strobes", int'({bus.spi_select, bus.read_n, bus.write_n}), 3);
        chk("rstpoll_addr_data", int'({bus.mem_addr, bus.data_from_cpu}), 0);
        clr_state();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_one("after_rst", 1, 1, 64'h5E, 32'h2, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
